// File: rtl/fb_pkg.sv
// Shared framebuffer constants, scanout state encoding and the RGB332->RGB565 expander.
// The expander is only referenced when FB_SCANOUT_RGB565_EN is defined.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // Bit replication keeps full-scale values at full scale (8'hFF -> 16'hFFFF).
  function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
    return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
  endfunction

endpackage

// File: rtl/fb_scanout_fifo.sv
// Two-entry pixel FIFO between the framebuffer read port and the LCD handshake.
// Head is read straight from storage so it stays stable while the consumer stalls.
module fb_scanout_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wr_q, rd_q;
  logic [1:0]        cnt_q;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: one rotated full-frame scan per start, streamed over valid/ready.
// Define FB_SCANOUT_RGB565_EN to widen pix_data to 16 bits with RGB332->RGB565 expansion.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
`ifdef FB_SCANOUT_RGB565_EN
  localparam int PIX_W = 16
`else
  localparam int PIX_W = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        row_offset,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int                PIXELS  = WIDTH * HEIGHT;
  localparam int                CNT_W   = $clog2(PIXELS + 1);
  localparam logic [ADDR_W-1:0] WIDTH_V = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(PIXELS - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q;
  logic              done_q, done_d;

  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              pop, issue;
  logic [2:0]        occ;
  logic [7:0]        row_sel;
  logic [ADDR_W-1:0] row_ext, base;

  assign pop = pix_valid && pix_ready;

  // Occupancy after this cycle's pop; counting the pop is what sustains 1 pixel/clk.
  assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == ST_RUN) && (occ < 3'd2);

  // Out-of-range offsets fall back to row 0; base is a shift-add over the set bits of WIDTH.
  assign row_sel = ({24'd0, row_offset} < 32'(HEIGHT)) ? row_offset : 8'd0;
  assign row_ext = ADDR_W'(row_sel);

  always_comb begin
    base = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (WIDTH_V[i]) base = base + (row_ext << i);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = base;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_C) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (fifo_cnt == 2'd1) && !inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  fb_scanout_fifo #(.W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (inflight_q),
    .din_i   (mem_rdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign mem_addr   = addr_q;
  assign pix_valid  = (fifo_cnt != 2'd0);
`ifdef FB_SCANOUT_RGB565_EN
  assign pix_data   = rgb332_to_565(fifo_head);
`else
  assign pix_data   = fifo_head;
`endif

endmodule
